// File: rtl/mem_arbiter_if.sv
// Bundles the datapath-side request/handshake signals and the RAM-side signals of mem_arbiter.
// The slave modport is the arbiter itself. The master modport is the datapath plus RAM around it.
interface mem_arbiter_if #(
    parameter int WORD_W = 32
);
    logic              iREN_i;
    logic [WORD_W-1:0] iaddr_i;
    logic              dREN_i;
    logic              dWEN_i;
    logic [WORD_W-1:0] daddr_i;
    logic [WORD_W-1:0] dstore_i;
    logic [1:0]        ramstate_i;
    logic [WORD_W-1:0] ramload_i;
    logic              iwait_o;
    logic              dwait_o;
    logic [WORD_W-1:0] iload_o;
    logic [WORD_W-1:0] dload_o;
    logic [WORD_W-1:0] ramaddr_o;
    logic [WORD_W-1:0] ramstore_o;
    logic              ramREN_o;
    logic              ramWEN_o;
    logic              grant_d_o;

    modport slave (
        input  iREN_i, iaddr_i, dREN_i, dWEN_i, daddr_i, dstore_i, ramstate_i, ramload_i,
        output iwait_o, dwait_o, iload_o, dload_o, ramaddr_o, ramstore_o, ramREN_o, ramWEN_o,
               grant_d_o
    );

    modport master (
        output iREN_i, iaddr_i, dREN_i, dWEN_i, daddr_i, dstore_i, ramstate_i, ramload_i,
        input  iwait_o, dwait_o, iload_o, dload_o, ramaddr_o, ramstore_o, ramREN_o, ramWEN_o,
               grant_d_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data accesses.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } state_e;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e     state_q, state_d;
    logic [3:0] starveCnt_q, starveCnt_d;
    logic       dReq;
    logic       dDone;
    logic       iDone;

    // A withdrawn request never counts as complete, even if RAM reports ACCESS.
    assign dReq  = bus.dREN_i | bus.dWEN_i;
    assign dDone = (state_q == DSERV) && dReq && (bus.ramstate_i == RAM_ACCESS);
    assign iDone = (state_q == ISERV) && bus.iREN_i && (bus.ramstate_i == RAM_ACCESS);

    always_comb begin
        state_d     = state_q;
        starveCnt_d = starveCnt_q;
        case (state_q)
            IDLE: begin
                if (dReq && (!bus.iREN_i || (starveCnt_q < STARVE_LIM))) begin
                    state_d = DSERV;
                end else if (bus.iREN_i) begin
                    state_d = ISERV;
                end
            end
            DSERV: begin
                if (!dReq) begin
                    state_d = IDLE;
                end else if (dDone) begin
                    state_d = IDLE;
                    if (bus.iREN_i) begin
                        starveCnt_d = (starveCnt_q == 4'd15) ? starveCnt_q : starveCnt_q + 4'd1;
                    end else begin
                        starveCnt_d = 4'd0;
                    end
                end
            end
            ISERV: begin
                if (!bus.iREN_i) begin
                    state_d = IDLE;
                end else if (iDone) begin
                    state_d     = IDLE;
                    starveCnt_d = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            starveCnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
        end
    end

    // RAM-side drive is decoded from the registered state, so reset clears it immediately.
    always_comb begin
        bus.ramaddr_o  = '0;
        bus.ramstore_o = '0;
        bus.ramREN_o   = 1'b0;
        bus.ramWEN_o   = 1'b0;
        case (state_q)
            DSERV: begin
                bus.ramaddr_o = bus.daddr_i;
                if (bus.dWEN_i) begin
                    bus.ramWEN_o   = 1'b1;
                    bus.ramstore_o = bus.dstore_i;
                end else begin
                    bus.ramREN_o = 1'b1;
                end
            end
            ISERV: begin
                bus.ramaddr_o = bus.iaddr_i;
                bus.ramREN_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.iwait_o   = ~iDone;
    assign bus.dwait_o   = ~dDone;
    assign bus.iload_o   = bus.ramload_i;
    assign bus.dload_o   = bus.ramload_i;
    assign bus.grant_d_o = (state_q == DSERV);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a RAM responder with per-transaction stall/error plans,
// and a completion monitor that checks each wait pulse against the next expected transaction.
module tb_mem_arbiter;
    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef struct {
        logic        isData;
        logic        isWrite;
        logic [31:0] addr;
        logic [31:0] data;
    } sbItem_t;

    logic CLK;
    logic nRST;
    int   assertCount;
    int   failCount;
    int   doneCount;
    int   stallPlan;
    int   errPlan;

    sbItem_t     sbQueue[$];
    logic [31:0] ramMem[logic [31:0]];

    mem_arbiter_if #(.WORD_W(32)) bus ();

    mem_arbiter #(
        .WORD_W    (32),
        .STARVE_MAX(4)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] memRead(input logic [31:0] a);
        return ramMem.exists(a) ? ramMem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected,
                     $time);
        end
    endtask

    task automatic pushExpect(input logic isData, input logic isWrite, input logic [31:0] addr,
                              input logic [31:0] data);
        sbItem_t item;
        item.isData  = isData;
        item.isWrite = isWrite;
        item.addr    = addr;
        item.data    = isWrite ? data : memRead(addr);
        sbQueue.push_back(item);
    endtask

    task automatic applyStimulus(input logic iRen, input logic [31:0] iAddr, input logic dRen,
                                 input logic dWen, input logic [31:0] dAddr,
                                 input logic [31:0] dStore, input int stalls, input int errs);
        bus.iREN_i   = iRen;
        bus.iaddr_i  = iAddr;
        bus.dREN_i   = dRen;
        bus.dWEN_i   = dWen;
        bus.daddr_i  = dAddr;
        bus.dstore_i = dStore;
        stallPlan    = stalls;
        errPlan      = errs;
    endtask

    task automatic waitCompletions(input int n, input int budget);
        int startCount = doneCount;
        int cycles     = 0;
        while ((doneCount - startCount) < n && cycles < budget) begin
            @(negedge CLK);
            cycles++;
        end
        if ((doneCount - startCount) < n) begin
            checkOutput("completionTimeout", 32'(doneCount - startCount), 32'(n));
        end
    endtask

    // RAM responder: ERROR for errPlan cycles, then BUSY for stallPlan cycles, then ACCESS.
    initial begin
        int svcCycles = 0;
        bus.ramstate_i = RAM_FREE;
        bus.ramload_i  = 32'h0;
        forever begin
            @(posedge CLK);
            #2;
            if (bus.ramREN_o || bus.ramWEN_o) begin
                if (svcCycles < errPlan) bus.ramstate_i = RAM_ERROR;
                else if (svcCycles < errPlan + stallPlan) bus.ramstate_i = RAM_BUSY;
                else bus.ramstate_i = RAM_ACCESS;
                bus.ramload_i = memRead(bus.ramaddr_o);
                svcCycles++;
            end else begin
                bus.ramstate_i = RAM_FREE;
                bus.ramload_i  = 32'h0;
                svcCycles      = 0;
            end
        end
    end

    // Completion monitor: every wait pulse must match the head of the scoreboard.
    initial begin
        sbItem_t exp;
        ramMem[32'h40] = 32'h8C01_0004;
        forever begin
            @(negedge CLK);
            if (nRST && (!bus.iwait_o || !bus.dwait_o)) begin
                doneCount++;
                if (!bus.iwait_o && !bus.dwait_o) begin
                    checkOutput("bothWaitsLow", 32'h1, 32'h0);
                end else if (sbQueue.size() == 0) begin
                    checkOutput("unexpectedDone", 32'(sbQueue.size()), 32'h1);
                end else begin
                    exp = sbQueue.pop_front();
                    checkOutput("grantSide", {31'h0, !bus.dwait_o}, {31'h0, exp.isData});
                    checkOutput("grantD", {31'h0, bus.grant_d_o}, {31'h0, exp.isData});
                    checkOutput("ramAddr", bus.ramaddr_o, exp.addr);
                    if (exp.isWrite) begin
                        checkOutput("wrWEN", {31'h0, bus.ramWEN_o}, 32'h1);
                        checkOutput("wrREN", {31'h0, bus.ramREN_o}, 32'h0);
                        checkOutput("wrStore", bus.ramstore_o, exp.data);
                        ramMem[exp.addr] = exp.data;
                    end else begin
                        checkOutput("rdREN", {31'h0, bus.ramREN_o}, 32'h1);
                        checkOutput("rdLoad", exp.isData ? bus.dload_o : bus.iload_o, exp.data);
                    end
                end
            end
        end
    end

    initial begin
        assertCount = 0;
        failCount   = 0;
        doneCount   = 0;
        nRST        = 1'b0;
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);

        // Reset held with a fetch pending: nothing driven to RAM, both waits high.
        repeat (3) @(negedge CLK);
        checkOutput("rstREN", {31'h0, bus.ramREN_o}, 32'h0);
        checkOutput("rstWEN", {31'h0, bus.ramWEN_o}, 32'h0);
        checkOutput("rstAddr", bus.ramaddr_o, 32'h0);
        checkOutput("rstIwait", {31'h0, bus.iwait_o}, 32'h1);
        checkOutput("rstDwait", {31'h0, bus.dwait_o}, 32'h1);
        checkOutput("rstGrantD", {31'h0, bus.grant_d_o}, 32'h0);

        // Release: ISERV at the next edge, completes immediately with ACCESS.
        pushExpect(1'b0, 1'b0, 32'h40, 32'h0);
        nRST = 1'b1;
        @(negedge CLK);
        checkOutput("fetchAddr", bus.ramaddr_o, 32'h40);
        checkOutput("fetchIwait", {31'h0, bus.iwait_o}, 32'h0);
        @(posedge CLK); #1;
        bus.iREN_i = 1'b0;
        @(negedge CLK);
        checkOutput("fetchIwaitOneCycle", {31'h0, bus.iwait_o}, 32'h1);
        checkOutput("fetchIdleREN", {31'h0, bus.ramREN_o}, 32'h0);

        // Write with three BUSY cycles before ACCESS.
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3, 0);
        pushExpect(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        @(negedge CLK);
        checkOutput("wrBubbleWEN", {31'h0, bus.ramWEN_o}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            checkOutput("wrStallWEN", {31'h0, bus.ramWEN_o}, 32'h1);
            checkOutput("wrStallREN", {31'h0, bus.ramREN_o}, 32'h0);
            checkOutput("wrStallStore", bus.ramstore_o, 32'hDEAD_BEEF);
            checkOutput("wrStallDwait", {31'h0, bus.dwait_o}, (k == 3) ? 32'h0 : 32'h1);
        end
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
        @(negedge CLK);

        // Starvation: fetch held, data always pending -> D D D D I, then data wins again.
        @(posedge CLK); #1;
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'h0, 0, 0);
        for (int k = 0; k < 4; k++) pushExpect(1'b1, 1'b0, 32'h200, 32'h0);
        pushExpect(1'b0, 1'b0, 32'h300, 32'h0);
        pushExpect(1'b1, 1'b0, 32'h200, 32'h0);
        waitCompletions(6, 40);
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
        repeat (2) @(negedge CLK);
        checkOutput("starveQueue", 32'(sbQueue.size()), 32'h0);

        // Dual request: write wins over read.
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h260, 32'hCAFE_F00D, 0, 0);
        pushExpect(1'b1, 1'b1, 32'h260, 32'hCAFE_F00D);
        repeat (2) @(negedge CLK);
        checkOutput("dualWEN", {31'h0, bus.ramWEN_o}, 32'h1);
        checkOutput("dualREN", {31'h0, bus.ramREN_o}, 32'h0);
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
        @(negedge CLK);

        // Abort: read withdrawn while RAM is BUSY, no dwait pulse.
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h220, 32'h0, 5, 0);
        repeat (2) @(negedge CLK);
        checkOutput("abortGrant", {31'h0, bus.grant_d_o}, 32'h1);
        checkOutput("abortBusyDwait", {31'h0, bus.dwait_o}, 32'h1);
        @(posedge CLK); #1;
        bus.dREN_i = 1'b0;
        @(negedge CLK);
        checkOutput("abortDropDwait", {31'h0, bus.dwait_o}, 32'h1);
        @(negedge CLK);
        checkOutput("abortIdleGrant", {31'h0, bus.grant_d_o}, 32'h0);
        checkOutput("abortIdleREN", {31'h0, bus.ramREN_o}, 32'h0);
        stallPlan = 0;

        // ERROR twice then ACCESS: retried, completes only on ACCESS.
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h240, 32'h0, 0, 2);
        pushExpect(1'b1, 1'b0, 32'h240, 32'h0);
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checkOutput("errDwait", {31'h0, bus.dwait_o}, (k == 2) ? 32'h0 : 32'h1);
        end
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
        @(negedge CLK);

        // Async reset mid-write: RAM enables drop before any clock edge.
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h180, 32'h1234_5678, 10, 0);
        repeat (2) @(negedge CLK);
        checkOutput("arstPreWEN", {31'h0, bus.ramWEN_o}, 32'h1);
        #3 nRST = 1'b0;
        #1;
        checkOutput("arstWEN", {31'h0, bus.ramWEN_o}, 32'h0);
        checkOutput("arstStore", bus.ramstore_o, 32'h0);
        checkOutput("arstGrantD", {31'h0, bus.grant_d_o}, 32'h0);
        checkOutput("arstDwait", {31'h0, bus.dwait_o}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("queueDrained", 32'(sbQueue.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
